// File: rtl/seg_readback_decoder_if.sv
// seg_readback_decoder_if
// Bundles the segment readback bus. The decoder attaches through the slave
// modport. The display side or a monitor attaches through the master modport.
// Define SEG_READBACK_DP_EN to add the decimal point input and the dp output.
interface seg_readback_decoder_if #(
   parameter int CNT_W = 8
);
   logic [6:0]       i_hex;
   logic [3:0]       o_digit;
   logic             o_valid;
   logic             o_blank;
   logic             o_err;
   logic [CNT_W-1:0] o_upd_cnt;
`ifdef SEG_READBACK_DP_EN
   logic             i_hex_dp;
   logic             o_dp;

   modport slave (
      input  i_hex,
      input  i_hex_dp,
      output o_digit,
      output o_valid,
      output o_blank,
      output o_err,
      output o_upd_cnt,
      output o_dp
   );

   modport master (
      output i_hex,
      output i_hex_dp,
      input  o_digit,
      input  o_valid,
      input  o_blank,
      input  o_err,
      input  o_upd_cnt,
      input  o_dp
   );
`else
   modport slave (
      input  i_hex,
      output o_digit,
      output o_valid,
      output o_blank,
      output o_err,
      output o_upd_cnt
   );

   modport master (
      output i_hex,
      input  o_digit,
      input  o_valid,
      input  o_blank,
      input  o_err,
      input  o_upd_cnt
   );
`endif
endinterface

// File: rtl/seg_readback_decoder.sv
// seg_readback_decoder
// Reads back an active-low DE-series 7-segment bus and recovers the hex digit
// it shows. A pattern is committed only after STABLE_CYCLES identical
// consecutive samples. Each commit is reported with a one-cycle valid strobe,
// blank and error flags, and a wrapping commit counter.
// Optional feature macro: SEG_READBACK_DP_EN adds decimal point sampling
// (bus.i_hex_dp) and the committed decimal point output (bus.o_dp).
module seg_readback_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic                   i_clk,
   input logic                   i_rst,
   seg_readback_decoder_if.slave bus
);

`ifdef SEG_READBACK_DP_EN
   localparam int SW = 8;
`else
   localparam int SW = 7;
`endif

   // The stability counter saturates at STABLE_CYCLES-1 (at most 254).
   localparam logic [7:0]    CNT_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] ALL_OFF = {SW{1'b1}};

   typedef enum logic {
      S_UNSTABLE = 1'b0,
      S_STABLE   = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SW-1:0]    w_in;
   logic [SW-1:0]    r_sample;
   logic [SW-1:0]    r_committed;
   logic [7:0]       r_cnt;
   logic [7:0]       w_cnt_nxt;
   logic             w_same;
   logic             w_stable;
   logic             w_commit;
   logic             w_glyph_ok;
   logic [3:0]       w_glyph_dig;
   logic             w_blank_nxt;
   logic             w_err_nxt;
   logic [3:0]       r_digit;
   logic             r_valid;
   logic             r_blank;
   logic             r_err;
   logic [CNT_W-1:0] r_upd_cnt;
`ifdef SEG_READBACK_DP_EN
   logic             r_dp;
`endif

   // Active-low glyph decode. Returns {legal, digit}. Only the sixteen hex
   // glyphs are legal. Every other pattern reports legal=0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] res;
      res = 5'b0_0000;
      case (seg)
         7'h40:   res = {1'b1, 4'h0};
         7'h79:   res = {1'b1, 4'h1};
         7'h24:   res = {1'b1, 4'h2};
         7'h30:   res = {1'b1, 4'h3};
         7'h19:   res = {1'b1, 4'h4};
         7'h12:   res = {1'b1, 4'h5};
         7'h02:   res = {1'b1, 4'h6};
         7'h78:   res = {1'b1, 4'h7};
         7'h00:   res = {1'b1, 4'h8};
         7'h10:   res = {1'b1, 4'h9};
         7'h08:   res = {1'b1, 4'hA};
         7'h03:   res = {1'b1, 4'hB};
         7'h46:   res = {1'b1, 4'hC};
         7'h21:   res = {1'b1, 4'hD};
         7'h06:   res = {1'b1, 4'hE};
         7'h0E:   res = {1'b1, 4'hF};
         default: res = 5'b0_0000;
      endcase
      return res;
   endfunction

   // Stability counter increment. It saturates so that it holds while the
   // pattern stays put.
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == CNT_MAX) ? CNT_MAX : c + 8'd1;
   endfunction

`ifdef SEG_READBACK_DP_EN
   assign w_in = {bus.i_hex_dp, bus.i_hex};
`else
   assign w_in = bus.i_hex;
`endif

   assign w_same    = (w_in == r_sample);
   assign w_stable  = (r_cnt == CNT_MAX);
   assign w_cnt_nxt = w_same ? sat_inc(r_cnt) : 8'd0;

   // Classify the current sample. Only the segment bits matter; the decimal point is ignored.
   always_comb begin
      {w_glyph_ok, w_glyph_dig} = decode_glyph(r_sample[6:0]);
      w_blank_nxt               = (r_sample[6:0] == 7'h7F);
      w_err_nxt                 = !w_glyph_ok && !w_blank_nxt;
   end

   // Next-state and commit decision for the stability FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         S_UNSTABLE: begin
            if (w_stable) begin
               w_state_nxt = S_STABLE;
               w_commit    = (r_sample != r_committed);
            end
         end
         S_STABLE: begin
            // The counter also drops below saturation when the input changed
            // on the same edge the FSM entered S_STABLE. Leaving on that edge
            // lets the new pattern be judged on its own.
            if (!w_same || !w_stable) begin
               w_state_nxt = S_UNSTABLE;
            end
         end
         default: w_state_nxt = S_UNSTABLE;
      endcase
   end

   // Sample register, stability counter and FSM state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sample <= ALL_OFF;
         r_cnt    <= 8'd0;
         r_state  <= S_UNSTABLE;
      end else begin
         r_sample <= w_in;
         r_cnt    <= w_cnt_nxt;
         r_state  <= w_state_nxt;
      end
   end

   // Commit registers: committed pattern, decoded outputs, strobe and counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_committed <= ALL_OFF;
         r_digit     <= 4'h0;
         r_valid     <= 1'b0;
         r_blank     <= 1'b1;
         r_err       <= 1'b0;
         r_upd_cnt   <= '0;
`ifdef SEG_READBACK_DP_EN
         r_dp        <= 1'b0;
`endif
      end else begin
         r_valid <= w_commit;
         if (w_commit) begin
            r_committed <= r_sample;
            r_upd_cnt   <= r_upd_cnt + CNT_W'(1);
            r_blank     <= w_blank_nxt;
            r_err       <= w_err_nxt;
            if (w_glyph_ok) begin
               r_digit <= w_glyph_dig;
            end
`ifdef SEG_READBACK_DP_EN
            r_dp        <= ~r_sample[7];
`endif
         end
      end
   end

   assign bus.o_digit   = r_digit;
   assign bus.o_valid   = r_valid;
   assign bus.o_blank   = r_blank;
   assign bus.o_err     = r_err;
   assign bus.o_upd_cnt = r_upd_cnt;
`ifdef SEG_READBACK_DP_EN
   assign bus.o_dp      = r_dp;
`endif

endmodule
